// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq sequencer: op codes, 74181 select
// constants, FSM states and per-op pass count.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOTA  = 3'b101,
    OP_MUL   = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

  // 74181 select codes; arithmetic ones assume no carry-in
  localparam logic [3:0] S_ADD   = 4'b1001;
  localparam logic [3:0] S_AMB1  = 4'b0110;
  localparam logic [3:0] S_AND   = 4'b1011;
  localparam logic [3:0] S_OR    = 4'b1110;
  localparam logic [3:0] S_XOR   = 4'b0110;
  localparam logic [3:0] S_NOTA  = 4'b0000;
  localparam logic [3:0] S_PASSA = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] last_pass(input op_e op);
    case (op)
      OP_SUB:  last_pass = 4'd1;
      OP_MUL:  last_pass = 4'd15;
      default: last_pass = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_encode.sv
// Maps an operation and its current pass index onto the 74181 select/mode pins.
module alu_op_encode
  import alu_seq_pkg::*;
(
  input  op_e        i_op,
  input  logic [3:0] i_pass,
  output logic [3:0] o_s,
  output logic       o_m
);

  always_comb begin
    o_s = S_NOTA;
    o_m = 1'b1;
    case (i_op)
      OP_ADD: begin
        o_s = S_ADD;
        o_m = 1'b0;
      end
      // SUB: A-B-1 first, then increment the partial result
      OP_SUB: begin
        o_s = (i_pass == 4'd0) ? S_AMB1 : S_ADD;
        o_m = 1'b0;
      end
      OP_MUL: begin
        o_s = S_ADD;
        o_m = 1'b0;
      end
      OP_AND:   o_s = S_AND;
      OP_OR:    o_s = S_OR;
      OP_XOR:   o_s = S_XOR;
      OP_NOTA:  o_s = S_NOTA;
      OP_PASSA: o_s = S_PASSA;
      default: begin
        o_s = S_NOTA;
        o_m = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-pass sequencer driving an external 74181-style ALU: one pass per
// EXEC cycle, SUB in two passes, MUL as 16 shift-and-add passes.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the response holds stable while rsp_valid is high and rsp_ready is low.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_y,
  input  logic         alu_co,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic [2:0]   rsp_flags,
  output state_e       o_dbg_state
);

  state_e       r_state;
  state_e       w_next;
  op_e          r_op;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_acc;
  logic         r_c;
  logic [3:0]   r_pass;
  logic [W-1:0] r_y;
  logic [2:0]   r_flags;

  logic [3:0]   w_enc_s;
  logic         w_enc_m;
  logic         w_accept;
  logic         w_last;
  logic         w_upd;
  logic         w_use_acc;
  logic [W-1:0] w_res;
  logic         w_c;

  alu_op_encode u_enc (
    .i_op   (r_op),
    .i_pass (r_pass),
    .o_s    (w_enc_s),
    .o_m    (w_enc_m)
  );

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_last    = (r_pass == last_pass(r_op));
  // MUL skips the add result when the multiplier bit is clear
  assign w_upd     = (r_op != OP_MUL) || r_a[r_pass];
  assign w_res     = w_upd ? alu_y : r_acc;
  assign w_c       = w_upd ? alu_co : r_c;
  assign w_use_acc = (r_op == OP_MUL) || ((r_op == OP_SUB) && (r_pass != 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next = ST_EXEC;
      ST_EXEC: if (w_last) w_next = ST_DONE;
      ST_DONE: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_s = S_NOTA;
    alu_m = 1'b1;
    alu_a = '0;
    alu_b = '0;
    if (r_state == ST_EXEC) begin
      alu_s = w_enc_s;
      alu_m = w_enc_m;
      alu_a = w_use_acc ? r_acc : r_a;
      if (r_op == OP_MUL)   alu_b = r_b << r_pass;
      else if (w_use_acc)   alu_b = W'(1);
      else                  alu_b = r_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_pass  <= '0;
      r_y     <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_op   <= op_e'(req_op);
      r_a    <= req_a;
      r_b    <= req_b;
      r_acc  <= '0;
      r_c    <= 1'b0;
      r_pass <= '0;
    end else if (r_state == ST_EXEC) begin
      r_acc  <= w_res;
      r_c    <= w_c;
      r_pass <= r_pass + 4'd1;
      if (w_last) begin
        r_y     <= w_res;
        r_flags <= {w_c, w_res[W-1], (w_res == '0)};
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_DONE);
  assign rsp_y       = r_y;
  assign rsp_flags   = r_flags;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a behavioural 74181 on the alu_* pins, a directed
// vector table, hand sequences for stall/reset, and randomized checks.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]  req_op, rsp_flags;
  logic [15:0] req_a, req_b, alu_a, alu_b, alu_y, rsp_y;
  logic [3:0]  alu_s;
  logic        alu_m, alu_co;
  state_e      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_f_q[$];

  alu_seq #(.W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_s(alu_s), .alu_m(alu_m), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_co(alu_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural 74181 (active-high data, no carry-in), only the used functions
  always_comb begin
    alu_co = 1'b0;
    alu_y  = 16'h0000;
    if (!alu_m) begin
      if (alu_s == 4'b1001)      {alu_co, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      else if (alu_s == 4'b0110) {alu_co, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b};
    end else begin
      case (alu_s)
        4'b0000: alu_y = ~alu_a;
        4'b0110: alu_y = alu_a ^ alu_b;
        4'b1011: alu_y = alu_a & alu_b;
        4'b1110: alu_y = alu_a | alu_b;
        4'b1111: alu_y = alu_a;
        default: alu_y = 16'h0000;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain arithmetic. Returns {flags{C,N,Z}, y}.
  function automatic logic [18:0] ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] y;
    logic        c;
    logic [31:0] prod;
    logic [16:0] sum;
    logic [15:0] partial;
    y = 16'h0; c = 1'b0;
    case (op)
      3'b000: begin sum = 17'(a) + 17'(b); y = sum[15:0]; c = sum[16]; end
      3'b001: begin y = a - b; c = (a == b); end   // final +1 carries only when A-B-1 wrapped to all ones
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = ~a;
      3'b110: begin
        prod = 32'(a) * 32'(b);
        y = prod[15:0];
        partial = 16'h0;
        for (int i = 0; i < 16; i++) begin
          if (a[i]) begin
            sum = 17'(partial) + 17'(16'(b << i));
            partial = sum[15:0];
            c = sum[16];
          end
        end
      end
      default: y = a;
    endcase
    return {c, y[15], (y == 16'h0), y};
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    if (op == 3'b001) return 2;
    if (op == 3'b110) return 16;
    return 1;
  endfunction

  // driver: issues one request, scrambles inputs while busy, returns at DONE
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] y, output logic [2:0] f, output int lat,
                        output logic [3:0] s0, output logic m0);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    s0 = alu_s; m0 = alu_m;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      req_valid = 1'b1;
      req_op = 3'($urandom_range(0, 7));
      req_a  = 16'($urandom);
      req_b  = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    y = rsp_y; f = rsp_flags;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("ready_after_rsp", {req_ready, rsp_valid}, 2'b10);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, y;
    logic [2:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [15:0] y, ystore;
    logic [2:0]  f;
    logic [3:0]  s0;
    logic        m0, seen;
    logic [18:0] r;
    int          lat;
    logic [2:0]  op;
    logic [15:0] a, b;

    vecs[0]  = '{3'b000, 16'h1234, 16'h0001, 16'h1235, 3'b000, 1};
    vecs[1]  = '{3'b001, 16'h0005, 16'h0003, 16'h0002, 3'b000, 2};
    vecs[2]  = '{3'b110, 16'h0003, 16'h0005, 16'h000F, 3'b000, 16};
    vecs[3]  = '{3'b110, 16'h0100, 16'h0100, 16'h0000, 3'b001, 16};
    vecs[4]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 3'b101, 1};
    vecs[5]  = '{3'b001, 16'h0003, 16'h0003, 16'h0000, 3'b101, 2};
    vecs[6]  = '{3'b001, 16'h0003, 16'h0005, 16'hFFFE, 3'b010, 2};
    vecs[7]  = '{3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000, 1};
    vecs[8]  = '{3'b011, 16'h1200, 16'h0034, 16'h1234, 3'b000, 1};
    vecs[9]  = '{3'b101, 16'h00FF, 16'h1234, 16'hFF00, 3'b010, 1};
    vecs[10] = '{3'b111, 16'h8000, 16'h5555, 16'h8000, 3'b010, 1};
    vecs[11] = '{3'b110, 16'h0000, 16'h1234, 16'h0000, 3'b001, 16};

    rst = 1'b1; req_valid = 1'b0; req_op = 3'b0; req_a = 16'h0; req_b = 16'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hs", {req_ready, rsp_valid}, 2'b10);
    check("reset_rsp", {rsp_y, rsp_flags}, 19'h0);
    check("reset_alu", {alu_s, alu_m, alu_a, alu_b}, {4'b0000, 1'b1, 32'h0});
    rst = 1'b0;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, y, f, lat, s0, m0);
      check($sformatf("vec%0d_y", i), y, vecs[i].y);
      check($sformatf("vec%0d_flags", i), f, vecs[i].f);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_done_alu", i), {alu_s, alu_m, alu_a, alu_b}, {4'b0000, 1'b1, 32'h0});
      finish_rsp();
    end

    // SUB first pass uses A-B-1 arithmetic mode
    run_op(3'b001, 16'h0005, 16'h0003, y, f, lat, s0, m0);
    check("sub_pass0_sel", {s0, m0}, {4'b0110, 1'b0});
    check("sub_y", y, 16'h0002);
    finish_rsp();

    // XOR with consumer stalled for 5 cycles while requests are offered
    run_op(3'b100, 16'hFFFF, 16'h00FF, y, f, lat, s0, m0);
    check("xor_y", y, 16'hFF00);
    check("xor_flags", f, 3'b010);
    ystore = y;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_op = 3'b000; req_a = 16'($urandom); req_b = 16'($urandom);
      @(negedge clk);
      check($sformatf("stall%0d", k), {rsp_y, rsp_valid, req_ready}, {ystore, 1'b1, 1'b0});
    end
    req_valid = 1'b0;
    finish_rsp();

    // reset in the middle of MUL, at pass 7
    req_valid = 1'b1; req_op = 3'b110; req_a = 16'hFFFF; req_b = 16'h0003;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_mul_busy", {req_ready, rsp_valid}, 2'b00);
    rst = 1'b1;
    #1;
    check("abort_hs", {req_ready, rsp_valid}, 2'b10);
    check("abort_alu", {alu_s, alu_m, alu_a, alu_b}, {4'b0000, 1'b1, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", seen, 1'b0);
    run_op(3'b000, 16'h0001, 16'h0001, y, f, lat, s0, m0);
    check("post_abort_add", {y, f}, {16'h0002, 3'b000});
    finish_rsp();

    // randomized against the reference model
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = 16'hFFFF;
        1: a = 16'($urandom_range(0, 3));
        default: a = 16'($urandom);
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
      r = ref_model(op, a, b);
      exp_q.push_back(r[15:0]);
      exp_f_q.push_back({13'h0, r[18:16]});
      run_op(op, a, b, y, f, lat, s0, m0);
      check($sformatf("rnd%0d_op%0d_y", n, op), y, exp_q.pop_front());
      check($sformatf("rnd%0d_op%0d_flags", n, op), {13'h0, f}, exp_f_q.pop_front());
      check($sformatf("rnd%0d_lat", n), lat, exp_lat(op));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check($sformatf("rnd%0d_hold", n), {rsp_y, rsp_valid}, {y, 1'b1});
      end
      finish_rsp();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
